multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//   Multi-cycle control FSM for the MIPS datapath (addu, subu, ori, lw, sw, beq, lui, jal, jr, nop).
//   Sequences one shared ALU and one shared instruction/data memory over FETCH/DECODE/EXEC/MEM/WB.
//   Waits on a memory ready handshake, counts retired instructions and flags illegal encodings.
//   Drives the PC, IR, register-file, memory-port and ALU controls of the multi-cycle datapath.
// PARAMETERS
//   CNT_W   32   width of the retired-instruction counter
// PORTS
//   clk          in   1      single clock; all state updates on the rising edge
//   reset_n      in   1      reset; asynchronous, active-low
//   opcode       in   6      IR[31:26]; stable from DECODE until the instruction retires
//   funct        in   6      IR[5:0]
//   zero         in   1      ALU zero flag; sampled in EXEC
//   mem_ready    in   1      memory completes the current mem_req in this cycle
//   pc_write     out  1      PC load strobe
//   pc_src       out  2      0 = PC+4, 1 = branch target, 2 = jal target, 3 = rs (jr)
//   ir_write     out  1      IR load strobe
//   mem_req      out  1      memory access request; held until mem_ready
//   mem_write    out  1      store strobe; only valid with mem_req
//   iord         out  1      memory address select: 0 = PC, 1 = ALU result
//   reg_write    out  1      register-file write strobe
//   reg_dst      out  2      0 = rt, 1 = rd, 2 = $31
//   what_to_reg  out  2      0 = ALU, 1 = MDR, 2 = PC (already PC+4)
//   alu_src      out  1      0 = rt value, 1 = extended immediate
//   ext_op       out  2      0 = zero-extend, 1 = sign-extend, 2 = imm<<16
//   alu_ctrl     out  3      0 = add, 1 = sub, 2 = or
//   state        out  3      FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
//   illegal      out  1      one-cycle pulse in DECODE for an unsupported opcode/funct
//   retired      out  CNT_W  count of retired instructions
// BEHAVIOUR
// - Reset (reset_n=0): state=FETCH, retired=0.
//   All strobes forced low while reset_n=0: pc_write, ir_write, mem_req, mem_write, reg_write, illegal.
//   Select outputs read 0 during reset. Reset mid-instruction abandons it; no write strobe may leak.
// - Outputs are combinational from the state register plus opcode/funct/zero/mem_ready.
//   Selects not listed for a state read 0.
// - FETCH: mem_req=1, iord=0.
//   mem_ready=0 -> stay in FETCH.
//   mem_ready=1 -> ir_write=1, pc_write=1 (pc_src=0), go to DECODE.
// - DECODE: ext_op=1, alu computes PC+4+(imm<<2) for the branch target.
//   jal -> reg_write=1, reg_dst=2, what_to_reg=2, pc_write=1, pc_src=2, retire, go to FETCH.
//   jr  -> pc_write=1, pc_src=3, retire, go to FETCH.
//   nop (all-zero word) -> retire, go to FETCH.
//   Unsupported opcode/funct -> illegal=1, treated as nop (retired still increments), go to FETCH.
//   Otherwise -> go to EXEC.
// - EXEC:
//   addu -> alu_src=0, alu_ctrl=0.   subu -> alu_src=0, alu_ctrl=1.
//   ori  -> alu_src=1, ext_op=0, alu_ctrl=2.   lui -> alu_src=1, ext_op=2, alu_ctrl=2.
//   lw/sw -> alu_src=1, ext_op=1, alu_ctrl=0, go to MEM.
//   beq  -> alu_src=0, alu_ctrl=1. If zero=1: pc_write=1, pc_src=1. Either way retire, go to FETCH.
//   addu/subu/ori/lui -> go to WB.
// - MEM: mem_req=1, iord=1, alu_src=1, ext_op=1, alu_ctrl=0 (address held); sw also asserts mem_write=1.
//   mem_ready=0 -> stay, outputs unchanged.
//   mem_ready=1 -> sw: retire, go to FETCH. lw: go to WB (datapath latches MDR).
// - WB: reg_write=1.
//   R-type: reg_dst=1, what_to_reg=0.  ori/lui: reg_dst=0, what_to_reg=0.  lw: reg_dst=0, what_to_reg=1.
//   Retire, go to FETCH.
// - Retire: retired increments on the edge that leaves the final state. It wraps modulo 2^CNT_W.
// - Latency with zero-wait memory: jal/jr/nop 2 cycles; beq 3; addu/subu/ori/lui/sw 4; lw 5.
//   Each memory wait cycle adds 1.
// - State encodings 5..7 are unreachable; if entered, next state = FETCH with all strobes low.
// TESTING
// - Reset, then addu $3,$1,$2 with mem_ready=1:
//     states 0,1,2,4; reg_write only in WB with reg_dst=1; retired=1.
// - lw with mem_ready low for 3 cycles in MEM:
//     mem_req/iord held 3 cycles; WB what_to_reg=1; total 8 cycles.
// - beq with zero=1, then beq with zero=0:
//     pc_write=1 with pc_src=1 only for the first; each takes 3 cycles.
// - jal then jr $31:
//     jal: DECODE asserts reg_write, reg_dst=2, pc_src=2. jr: pc_src=3. retired +2 in 4 cycles.
// - opcode 6'h3f: illegal pulses 1 cycle, no write strobes, FETCH next.
//   Separately, reset_n low during MEM of sw: mem_write drops immediately, state=0.
// - Preload retired to 2^CNT_W-1 (force), retire a nop -> retired=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle controller and the MIPS datapath.
// The controller takes the master side: it drives every control strobe and select,
// and the datapath (slave) returns the decoded IR fields, the ALU zero flag and
// the memory ready handshake.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             mem_req;
  logic             mem_write;
  logic             iord;
  logic             reg_write;
  logic [1:0]       reg_dst;
  logic [1:0]       what_to_reg;
  logic             alu_src;
  logic [1:0]       ext_op;
  logic [2:0]       alu_ctrl;
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_src, ir_write, mem_req, mem_write, iord, reg_write,
           reg_dst, what_to_reg, alu_src, ext_op, alu_ctrl, state, illegal, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_src, ir_write, mem_req, mem_write, iord, reg_write,
           reg_dst, what_to_reg, alu_src, ext_op, alu_ctrl, state, illegal, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for a MIPS subset (addu, subu, ori, lw, sw, beq, lui,
// jal, jr, nop). One shared ALU and one shared memory are sequenced over
// FETCH/DECODE/EXEC/MEM/WB; controls are decoded from the state register and the
// live IR fields, and are all held at zero while reset_n is low.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_JAL, C_JR, C_NOP, C_ILL
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] F_NOP    = 6'h00;
  localparam logic [5:0] F_JR     = 6'h08;
  localparam logic [5:0] F_ADDU   = 6'h21;
  localparam logic [5:0] F_SUBU   = 6'h23;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;
  cls_t             w_cls;
  logic             w_retire;

  logic       w_pc_write, w_ir_write, w_mem_req, w_mem_write, w_iord;
  logic       w_reg_write, w_alu_src, w_illegal;
  logic [1:0] w_pc_src, w_reg_dst, w_what_to_reg, w_ext_op;
  logic [2:0] w_alu_ctrl;

  // Classify the instruction held in IR; anything not recognised is illegal.
  always_comb begin
    w_cls = C_ILL;
    case (bus.opcode)
      OP_RTYPE: begin
        case (bus.funct)
          F_NOP:   w_cls = C_NOP;
          F_JR:    w_cls = C_JR;
          F_ADDU:  w_cls = C_ADDU;
          F_SUBU:  w_cls = C_SUBU;
          default: w_cls = C_ILL;
        endcase
      end
      OP_JAL:  w_cls = C_JAL;
      OP_BEQ:  w_cls = C_BEQ;
      OP_ORI:  w_cls = C_ORI;
      OP_LUI:  w_cls = C_LUI;
      OP_LW:   w_cls = C_LW;
      OP_SW:   w_cls = C_SW;
      default: w_cls = C_ILL;
    endcase
  end

  // Next-state, retire and control decode for the current state.
  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_next        = S_FETCH;
    w_retire      = 1'b0;
    w_pc_write    = 1'b0;
    w_pc_src      = 2'd0;
    w_ir_write    = 1'b0;
    w_mem_req     = 1'b0;
    w_mem_write   = 1'b0;
    w_iord        = 1'b0;
    w_reg_write   = 1'b0;
    w_reg_dst     = 2'd0;
    w_what_to_reg = 2'd0;
    w_alu_src     = 1'b0;
    w_ext_op      = 2'd0;
    w_alu_ctrl    = 3'd0;
    w_illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        // ALU forms the branch target PC+4+(imm<<2) while the class is resolved.
        w_ext_op = 2'd1;
        case (w_cls)
          C_JAL: begin
            w_reg_write   = 1'b1;
            w_reg_dst     = 2'd2;
            w_what_to_reg = 2'd2;
            w_pc_write    = 1'b1;
            w_pc_src      = 2'd2;
            w_retire      = 1'b1;
          end
          C_JR: begin
            w_pc_write = 1'b1;
            w_pc_src   = 2'd3;
            w_retire   = 1'b1;
          end
          C_NOP: w_retire = 1'b1;
          C_ILL: begin
            w_illegal = 1'b1;
            w_retire  = 1'b1;
          end
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (w_cls)
          C_ADDU: w_next = S_WB;
          C_SUBU: begin
            w_alu_ctrl = 3'd1;
            w_next     = S_WB;
          end
          C_ORI: begin
            w_alu_src  = 1'b1;
            w_alu_ctrl = 3'd2;
            w_next     = S_WB;
          end
          C_LUI: begin
            w_alu_src  = 1'b1;
            w_ext_op   = 2'd2;
            w_alu_ctrl = 3'd2;
            w_next     = S_WB;
          end
          C_LW, C_SW: begin
            w_alu_src = 1'b1;
            w_ext_op  = 2'd1;
            w_next    = S_MEM;
          end
          C_BEQ: begin
            w_alu_ctrl = 3'd1;
            w_pc_write = bus.zero;
            w_pc_src   = bus.zero ? 2'd1 : 2'd0;
            w_retire   = 1'b1;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        // Address computation is held so the memory sees a stable address while waiting.
        w_mem_req   = 1'b1;
        w_iord      = 1'b1;
        w_alu_src   = 1'b1;
        w_ext_op    = 2'd1;
        w_mem_write = (w_cls == C_SW);
        if (!bus.mem_ready) begin
          w_next = S_MEM;
        end else if (w_cls == C_LW) begin
          w_next = S_WB;
        end else begin
          w_retire = 1'b1;
        end
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        if (w_cls == C_ADDU || w_cls == C_SUBU) w_reg_dst = 2'd1;
        if (w_cls == C_LW) w_what_to_reg = 2'd1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // State register and retired-instruction counter.
  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  // NOTE: reset is asynchronous; reset mid-instruction drops it and returns to FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Outputs are gated by reset_n so no strobe can leak while reset is asserted.
  assign bus.pc_write    = reset_n & w_pc_write;
  assign bus.ir_write    = reset_n & w_ir_write;
  assign bus.mem_req     = reset_n & w_mem_req;
  assign bus.mem_write   = reset_n & w_mem_write;
  assign bus.iord        = reset_n & w_iord;
  assign bus.reg_write   = reset_n & w_reg_write;
  assign bus.alu_src     = reset_n & w_alu_src;
  assign bus.illegal     = reset_n & w_illegal;
  assign bus.pc_src      = reset_n ? w_pc_src      : 2'd0;
  assign bus.reg_dst     = reset_n ? w_reg_dst     : 2'd0;
  assign bus.what_to_reg = reset_n ? w_what_to_reg : 2'd0;
  assign bus.ext_op      = reset_n ? w_ext_op      : 2'd0;
  assign bus.alu_ctrl    = reset_n ? w_alu_ctrl    : 3'd0;
  assign bus.state       = r_state;
  assign bus.retired     = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instruction scenarios
// followed by randomized instructions, memory waits and zero flags, each cycle
// compared against the outputs expected from the instruction-level rules.
module tb_multicycle_controller;

  localparam int CNT_W = 4;

  typedef enum int {
    I_ADDU, I_SUBU, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL, I_JR, I_NOP, I_ILL
  } ins_t;

  typedef struct packed {
    logic [2:0]       state;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             ir_write;
    logic             mem_req;
    logic             mem_write;
    logic             iord;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic [1:0]       what_to_reg;
    logic             alu_src;
    logic [1:0]       ext_op;
    logic [2:0]       alu_ctrl;
    logic             illegal;
    logic [CNT_W-1:0] retired;
  } ctl_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks    = 0;
  int   failures  = 0;
  int   n_retired = 0;

  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic ctl_t observe();
    ctl_t o;
    o.state       = bus.state;
    o.pc_write    = bus.pc_write;
    o.pc_src      = bus.pc_src;
    o.ir_write    = bus.ir_write;
    o.mem_req     = bus.mem_req;
    o.mem_write   = bus.mem_write;
    o.iord        = bus.iord;
    o.reg_write   = bus.reg_write;
    o.reg_dst     = bus.reg_dst;
    o.what_to_reg = bus.what_to_reg;
    o.alu_src     = bus.alu_src;
    o.ext_op      = bus.ext_op;
    o.alu_ctrl    = bus.alu_ctrl;
    o.illegal     = bus.illegal;
    o.retired     = bus.retired;
    return o;
  endfunction

  function automatic logic [CNT_W-1:0] model_retired();
    return CNT_W'(n_retired % (1 << CNT_W));
  endfunction

  task automatic check(input string tag, input ctl_t obs, input ctl_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check one cycle: outputs sampled on the falling edge, then advance to just after the rising edge.
  task automatic step(input string tag, input ctl_t e);
    @(negedge clk);
    e.retired = model_retired();
    check(tag, observe(), e);
    @(posedge clk);
    #1;
  endtask

  function automatic void enc(input ins_t i, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    case (i)
      I_ADDU: begin op = 6'h00; fn = 6'h21; end
      I_SUBU: begin op = 6'h00; fn = 6'h23; end
      I_JR:   begin op = 6'h00; fn = 6'h08; end
      I_NOP:  begin op = 6'h00; fn = 6'h00; end
      I_ORI:  op = 6'h0d;
      I_LW:   op = 6'h23;
      I_SW:   op = 6'h2b;
      I_BEQ:  op = 6'h04;
      I_LUI:  op = 6'h0f;
      I_JAL:  op = 6'h03;
      default: begin
        case ($urandom_range(0, 4))
          0:       op = 6'h3f;
          1:       op = 6'h02;
          2:       op = 6'h08;
          3:       op = 6'h01;
          default: begin op = 6'h00; fn = 6'h20; end
        endcase
      end
    endcase
  endfunction

  // Run one instruction from FETCH to retirement, checking every cycle.
  // fw/mw are memory wait cycles in FETCH/MEM; abort applies reset in the first MEM cycle.
  task automatic run_instr(input ins_t i, input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input logic z, input bit abort);
    ctl_t e;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    // FETCH
    for (int k = 0; k < fw; k++) begin
      bus.mem_ready = 1'b0;
      e = '0; e.mem_req = 1'b1;
      step("fetch_wait", e);
    end
    bus.mem_ready = 1'b1;
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    step("fetch", e);
    // DECODE: memory handshake is irrelevant here, so drive it randomly
    bus.mem_ready = 1'($urandom);
    e = '0; e.state = 3'd1; e.ext_op = 2'd1;
    case (i)
      I_JAL: begin
        e.reg_write = 1'b1; e.reg_dst = 2'd2; e.what_to_reg = 2'd2;
        e.pc_write = 1'b1; e.pc_src = 2'd2;
      end
      I_JR:  begin e.pc_write = 1'b1; e.pc_src = 2'd3; end
      I_ILL: e.illegal = 1'b1;
      default: ;
    endcase
    step("decode", e);
    if (i inside {I_JAL, I_JR, I_NOP, I_ILL}) begin
      n_retired++;
      return;
    end
    // EXEC
    bus.mem_ready = 1'($urandom);
    e = '0; e.state = 3'd2;
    case (i)
      I_SUBU: e.alu_ctrl = 3'd1;
      I_ORI:  begin e.alu_src = 1'b1; e.alu_ctrl = 3'd2; end
      I_LUI:  begin e.alu_src = 1'b1; e.ext_op = 2'd2; e.alu_ctrl = 3'd2; end
      I_LW, I_SW: begin e.alu_src = 1'b1; e.ext_op = 2'd1; end
      I_BEQ: begin
        e.alu_ctrl = 3'd1;
        if (z) begin e.pc_write = 1'b1; e.pc_src = 2'd1; end
      end
      default: ;
    endcase
    step("exec", e);
    if (i == I_BEQ) begin
      n_retired++;
      return;
    end
    // MEM
    if (i inside {I_LW, I_SW}) begin
      e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.iord = 1'b1;
      e.alu_src = 1'b1; e.ext_op = 2'd1; e.mem_write = (i == I_SW);
      if (abort) begin
        bus.mem_ready = 1'b0;
        @(negedge clk);
        e.retired = model_retired();
        check("mem_before_reset", observe(), e);
        #2 reset_n = 1'b0;
        n_retired = 0;
        #1 check("reset_async", observe(), ctl_t'(0));
        @(posedge clk);
        #1 check("reset_edge", observe(), ctl_t'(0));
        reset_n = 1'b1;
        return;
      end
      for (int k = 0; k < mw; k++) begin
        bus.mem_ready = 1'b0;
        step("mem_wait", e);
      end
      bus.mem_ready = 1'b1;
      step("mem", e);
      if (i == I_SW) begin
        n_retired++;
        return;
      end
    end
    // WB
    bus.mem_ready = 1'($urandom);
    e = '0; e.state = 3'd4; e.reg_write = 1'b1;
    if (i inside {I_ADDU, I_SUBU}) e.reg_dst = 2'd1;
    if (i == I_LW) e.what_to_reg = 2'd1;
    step("wb", e);
    n_retired++;
  endtask

  task automatic run_rand(input ins_t i);
    logic [5:0] op, fn;
    enc(i, op, fn);
    run_instr(i, op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), 1'b0);
  endtask

  initial begin
    ctl_t obs;
    reset_n       = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    #1 check("reset_outputs", observe(), ctl_t'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;

    // addu $3,$1,$2 with zero-wait memory
    run_instr(I_ADDU, 6'h00, 6'h21, 0, 0, 1'b0, 1'b0);
    // lw with three memory wait cycles in MEM
    run_instr(I_LW, 6'h23, 6'h15, 0, 3, 1'b0, 1'b0);
    // beq taken, then not taken
    run_instr(I_BEQ, 6'h04, 6'h01, 0, 0, 1'b1, 1'b0);
    run_instr(I_BEQ, 6'h04, 6'h01, 0, 0, 1'b0, 1'b0);
    // jal then jr $31
    run_instr(I_JAL, 6'h03, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr(I_JR, 6'h00, 6'h08, 0, 0, 1'b0, 1'b0);
    // unsupported opcode
    run_instr(I_ILL, 6'h3f, 6'h00, 0, 0, 1'b0, 1'b0);
    // fetch waits on the remaining instruction types
    run_instr(I_SUBU, 6'h00, 6'h23, 2, 0, 1'b1, 1'b0);
    run_instr(I_ORI, 6'h0d, 6'h3c, 1, 0, 1'b0, 1'b0);
    run_instr(I_LUI, 6'h0f, 6'h2a, 0, 0, 1'b0, 1'b0);
    run_instr(I_SW, 6'h2b, 6'h07, 1, 2, 1'b0, 1'b0);
    // reset during MEM of sw
    run_instr(I_SW, 6'h2b, 6'h00, 0, 0, 1'b0, 1'b1);
    run_instr(I_NOP, 6'h00, 6'h00, 0, 0, 1'b0, 1'b0);

    // counter wrap: bring the count to all-ones, then retire one nop
    while (n_retired % (1 << CNT_W) != (1 << CNT_W) - 1)
      run_instr(I_NOP, 6'h00, 6'h00, 0, 0, 1'b0, 1'b0);
    obs = observe();
    checks++;
    assert (obs.retired === CNT_W'((1 << CNT_W) - 1)) else begin
      failures++;
      $error("FAIL retired_full observed=%0d expected=%0d", obs.retired, (1 << CNT_W) - 1);
    end
    run_instr(I_NOP, 6'h00, 6'h00, 0, 0, 1'b0, 1'b0);
    obs = observe();
    checks++;
    assert (obs.retired === '0) else begin
      failures++;
      $error("FAIL retired_wrap observed=%0d expected=0", obs.retired);
    end

    // randomized instruction stream
    for (int n = 0; n < 80; n++) run_rand(ins_t'($urandom_range(0, 10)));

    obs = observe();
    checks++;
    assert (obs.retired === model_retired() && obs.state === 3'd0) else begin
      failures++;
      $error("FAIL final_state observed=%0d/%0d expected=%0d/0",
             obs.retired, obs.state, model_retired());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
